// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, operand-B select codes,
// ALU control codes and the ID->EX register bundle.
package cpu_defs;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 3;

    localparam logic [1:0] B_SEL_RT   = 2'd0;
    localparam logic [1:0] B_SEL_SEXT = 2'd1;
    localparam logic [1:0] B_SEL_ZEXT = 2'd2;
    localparam logic [1:0] B_SEL_RSV  = 2'd3;

    localparam logic [CTRL_W-1:0] ALU_AND = 3'd0;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'd1;
    localparam logic [CTRL_W-1:0] ALU_ADD = 3'd2;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'd3;
    localparam logic [CTRL_W-1:0] ALU_SLT = 3'd4;
    localparam logic [CTRL_W-1:0] ALU_SLL = 3'd5;
    localparam logic [CTRL_W-1:0] ALU_SRL = 3'd6;
    localparam logic [CTRL_W-1:0] ALU_SRA = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]    a;
        logic [XLEN-1:0]    b;
        logic [CTRL_W-1:0]  alu_ctrl;
        logic [RADDR_W-1:0] rd;
        logic               reg_write;
        logic               mem_read;
    } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register.
// Ports: addr/rf_data in, EX/MEM and MEM/WB write ports in, fwd_data out.
module fwd_mux
    import cpu_defs::*;
(
    input  logic [RADDR_W-1:0] addr,
    input  logic [XLEN-1:0]    rf_data,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]    memwb_result,
    output logic [XLEN-1:0]    fwd_data
);

    logic hit_exmem;
    logic hit_memwb;

    // r0 is hard-wired zero, so it never takes a forwarded value
    assign hit_exmem = exmem_reg_write && (exmem_rd == addr)
                       && (addr != '0);
    assign hit_memwb = memwb_reg_write && (memwb_rd == addr)
                       && (addr != '0);

    // the younger producer (EX/MEM) wins over MEM/WB
    always_comb begin
        fwd_data = rf_data;
        if (hit_exmem) begin
            fwd_data = exmem_result;
        end else if (hit_memwb) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register: operand forwarding, load-use stall, flush.
// Ports: in_* from ID, exmem_*/memwb_* forwarding, ex_* to EX, stall to IF.
module id_ex_operand_stage
    import cpu_defs::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_inst,
    input  logic [XLEN-1:0]    in_rs_data,
    input  logic [XLEN-1:0]    in_rt_data,
    input  logic               in_uses_rs,
    input  logic               in_uses_rt,
    input  logic               in_a_sel,
    input  logic [1:0]         in_b_sel,
    input  logic [CTRL_W-1:0]  in_alu_ctrl,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_reg_write,
    input  logic               in_mem_read,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]    memwb_result,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [XLEN-1:0]    ex_a,
    output logic [XLEN-1:0]    ex_b,
    output logic [CTRL_W-1:0]  ex_alu_ctrl,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               stall
);

    id_ex_t             ex_q;
    id_ex_t             ex_d;
    logic               ex_valid_q;
    logic               ex_valid_d;
    logic               live_q;
    logic [RADDR_W-1:0] rs_addr;
    logic [RADDR_W-1:0] rt_addr;
    logic [XLEN-1:0]    fwd_rs;
    logic [XLEN-1:0]    fwd_rt;
    logic [XLEN-1:0]    a_d;
    logic [XLEN-1:0]    b_d;
    logic [15:0]        imm;
    logic               hazard;
    logic               transfer;
    logic               unused_opcode;

    assign rs_addr       = in_inst[25:21];
    assign rt_addr       = in_inst[20:16];
    assign imm           = in_inst[15:0];
    assign unused_opcode = ^in_inst[31:26];

    fwd_mux u_fwd_rs (
        .addr            (rs_addr),
        .rf_data         (in_rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .addr            (rt_addr),
        .rf_data         (in_rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rt)
    );

    // shifts take rt on A so the shamt field of imm lands on B[10:6]
    assign a_d = in_a_sel ? fwd_rt : fwd_rs;

    always_comb begin
        b_d = '0;
        unique case (in_b_sel)
            B_SEL_RT:   b_d = fwd_rt;
            B_SEL_SEXT: b_d = {{16{imm[15]}}, imm};
            B_SEL_ZEXT: b_d = {16'b0, imm};
            B_SEL_RSV:  b_d = '0;
            default:    b_d = '0;
        endcase
    end

    // a load in EX cannot forward yet: hold ID one cycle
    assign hazard = ex_valid_q && ex_q.mem_read && (ex_q.rd != '0)
                    && ((in_uses_rs && (ex_q.rd == rs_addr))
                     || (in_uses_rt && (ex_q.rd == rt_addr)));

    // live_q keeps in_ready low until the first edge after reset
    assign in_ready = live_q && (!ex_valid_q || ex_ready)
                      && !hazard && !flush;
    assign transfer = in_valid && in_ready;
    assign stall    = in_valid && hazard;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush) begin
            ex_valid_d     = 1'b0;
            ex_d.alu_ctrl  = '0;
            ex_d.rd        = '0;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
        end else if (transfer) begin
            ex_valid_d     = 1'b1;
            ex_d.a         = a_d;
            ex_d.b         = b_d;
            ex_d.alu_ctrl  = in_alu_ctrl;
            ex_d.rd        = in_rd;
            ex_d.reg_write = in_reg_write;
            ex_d.mem_read  = in_mem_read;
        end else if (ex_ready) begin
            ex_valid_d     = 1'b0;
            ex_d.alu_ctrl  = '0;
            ex_d.rd        = '0;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            live_q     <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            live_q     <= 1'b1;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_a         = ex_q.a;
    assign ex_b         = ex_q.b;
    assign ex_alu_ctrl  = ex_q.alu_ctrl;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_valid_q && ex_q.reg_write;
    assign ex_mem_read  = ex_valid_q && ex_q.mem_read;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios then random traffic,
// checked against a behavioural model of the stage.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        in_uses_rs;
    logic        in_uses_rt;
    logic        in_a_sel;
    logic [1:0]  in_b_sel;
    logic [2:0]  in_alu_ctrl;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [2:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit          m_live;
    bit          m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_ctrl;
    logic [4:0]  m_rd;
    bit          m_rw;
    bit          m_mr;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_inst         (in_inst),
        .in_rs_data      (in_rs_data),
        .in_rt_data      (in_rt_data),
        .in_uses_rs      (in_uses_rs),
        .in_uses_rt      (in_uses_rt),
        .in_a_sel        (in_a_sel),
        .in_b_sel        (in_b_sel),
        .in_alu_ctrl     (in_alu_ctrl),
        .in_rd           (in_rd),
        .in_reg_write    (in_reg_write),
        .in_mem_read     (in_mem_read),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_a            (ex_a),
        .ex_b            (ex_b),
        .ex_alu_ctrl     (ex_alu_ctrl),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .stall           (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int rs, input int rt,
                                       input int imm);
        logic [31:0] w;
        w = {6'd0, 5'(rs), 5'(rt), 16'(imm)};
        return w;
    endfunction

    // youngest writer first; r0 never takes a forwarded value
    function automatic logic [31:0] fwd(input logic [4:0] r,
                                        input logic [31:0] rf);
        logic        we[2];
        logic [4:0]  dst[2];
        logic [31:0] val[2];
        we[0] = exmem_reg_write; dst[0] = exmem_rd; val[0] = exmem_result;
        we[1] = memwb_reg_write; dst[1] = memwb_rd; val[1] = memwb_result;
        for (int i = 0; i < 2; i++)
            if (r != 0 && we[i] && dst[i] == r) return val[i];
        return rf;
    endfunction

    function automatic bit m_hazard();
        int rs = int'(in_inst[25:21]);
        int rt = int'(in_inst[20:16]);
        return m_valid && m_mr && m_rd != 0 &&
               ((in_uses_rs && int'(m_rd) == rs) ||
                (in_uses_rt && int'(m_rd) == rt));
    endfunction

    function automatic bit m_ready();
        return m_live && (!m_valid || ex_ready) && !m_hazard() && !flush;
    endfunction

    task automatic model_reset();
        m_live = 0; m_valid = 0; m_a = 0; m_b = 0;
        m_ctrl = 0; m_rd = 0; m_rw = 0; m_mr = 0;
    endtask

    task automatic model_step();
        logic [31:0] frs;
        logic [31:0] frt;
        logic [31:0] imm;
        bit          xfer;
        xfer = in_valid && m_ready();
        frs  = fwd(in_inst[25:21], in_rs_data);
        frt  = fwd(in_inst[20:16], in_rt_data);
        imm  = 32'(in_inst[15:0]);
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0;
        end else if (xfer) begin
            m_valid = 1;
            m_a     = in_a_sel ? frt : frs;
            case (in_b_sel)
                2'd0:    m_b = frt;
                2'd1:    m_b = 32'($signed(in_inst[15:0]));
                2'd2:    m_b = imm;
                default: m_b = 0;
            endcase
            m_ctrl = in_alu_ctrl; m_rd = in_rd;
            m_rw   = in_reg_write; m_mr = in_mem_read;
        end else if (ex_ready) begin
            m_valid = 0; m_rw = 0; m_mr = 0;
        end
        m_live = 1;
    endtask

    // one clock: handshake checks mid-cycle, register checks after edge
    task automatic cycle(input string tag);
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready()));
        chk({tag, ".stall"}, 32'(stall), 32'(in_valid && m_hazard()));
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
        chk({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(m_valid && m_rw));
        chk({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(m_valid && m_mr));
        if (m_valid) begin
            chk({tag, ".ex_a"}, ex_a, m_a);
            chk({tag, ".ex_b"}, ex_b, m_b);
            chk({tag, ".ex_alu_ctrl"}, 32'(ex_alu_ctrl), 32'(m_ctrl));
            chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(m_rd));
        end
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_inst = 0;
        in_rs_data = 0; in_rt_data = 0;
        in_uses_rs = 0; in_uses_rt = 0; in_a_sel = 0; in_b_sel = 0;
        in_alu_ctrl = 0; in_rd = 0; in_reg_write = 0; in_mem_read = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
        ex_ready = 1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ex_valid", 32'(ex_valid), 0);
        chk("rst.ex_a", ex_a, 0);
        chk("rst.ex_b", ex_b, 0);
        chk("rst.ex_alu_ctrl", 32'(ex_alu_ctrl), 0);
        chk("rst.ex_rd", 32'(ex_rd), 0);
        chk("rst.ex_reg_write", 32'(ex_reg_write), 0);
        chk("rst.ex_mem_read", 32'(ex_mem_read), 0);
        chk("rst.in_ready", 32'(in_ready), 0);
        chk("rst.stall", 32'(stall), 0);
        rst_n = 1;
        cycle("rel");

        // srl r3,r2,4
        in_valid = 1; in_inst = 32'h0002_1902; in_rt_data = 32'hF000_0000;
        in_uses_rt = 1; in_a_sel = 1; in_b_sel = 2;
        in_alu_ctrl = 3'd6; in_rd = 3; in_reg_write = 1;
        cycle("srl");
        chk("srl.a", ex_a, 32'hF000_0000);
        chk("srl.shamt", 32'(ex_b[10:6]), 4);
        chk("srl.valid", 32'(ex_valid), 1);

        // both stages write r5: EX/MEM wins
        idle_inputs();
        in_valid = 1; in_inst = mk(5, 0, 16'h8001); in_uses_rs = 1;
        in_rs_data = 32'h99; in_b_sel = 1; in_alu_ctrl = 3'd2;
        in_rd = 7; in_reg_write = 1;
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 11;
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 22;
        cycle("fwd5");
        chk("fwd5.a", ex_a, 11);
        chk("fwd5.sext", ex_b, 32'hFFFF_8001);
        in_inst = mk(0, 0, 0); in_rs_data = 32'h77;
        exmem_rd = 0; memwb_rd = 0;
        cycle("fwd0");
        chk("fwd0.a", ex_a, 32'h77);

        // load-use: lw r4 then add reading r4 as rt
        idle_inputs();
        in_valid = 1; in_inst = mk(1, 4, 8); in_uses_rs = 1;
        in_b_sel = 1; in_alu_ctrl = 3'd2; in_rd = 4;
        in_reg_write = 1; in_mem_read = 1;
        cycle("lw");
        in_inst = mk(1, 4, 0); in_uses_rt = 1; in_b_sel = 0;
        in_rd = 6; in_mem_read = 0; in_rt_data = 32'h1111;
        cycle("bubble");
        chk("bubble.valid", 32'(ex_valid), 0);
        chk("bubble.reg_write", 32'(ex_reg_write), 0);
        memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'hABCD;
        cycle("add");
        chk("add.b", ex_b, 32'hABCD);

        // back-pressure
        idle_inputs();
        in_valid = 1; in_inst = mk(2, 3, 5); in_rs_data = 32'h5555;
        in_uses_rs = 1; in_b_sel = 2; in_rd = 9; in_reg_write = 1;
        cycle("bp0");
        ex_ready = 0; in_rs_data = 32'h6666; in_rd = 10;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_hold.a", ex_a, 32'h5555);
        end
        ex_ready = 1;
        cycle("bp_go");
        chk("bp_go.a", ex_a, 32'h6666);

        // flush on a would-be transfer
        flush = 1; in_rs_data = 32'h7777;
        cycle("flush");
        chk("flush.valid", 32'(ex_valid), 0);
        flush = 0;

        // asynchronous reset mid-cycle with a load in EX
        in_mem_read = 1;
        cycle("pre_rst");
        #2;
        rst_n = 0;
        #1;
        chk("arst.ex_valid", 32'(ex_valid), 0);
        chk("arst.ex_reg_write", 32'(ex_reg_write), 0);
        chk("arst.ex_mem_read", 32'(ex_mem_read), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;

        // random traffic
        for (int i = 0; i < 300; i++) begin
            in_valid     = 1'($urandom_range(0, 3) != 0);
            in_inst      = mk($urandom_range(0, 7), $urandom_range(0, 7),
                              $urandom_range(0, 65535));
            in_rs_data   = $urandom;
            in_rt_data   = $urandom;
            in_uses_rs   = 1'($urandom);
            in_uses_rt   = 1'($urandom);
            in_a_sel     = 1'($urandom);
            in_b_sel     = 2'($urandom);
            in_alu_ctrl  = 3'($urandom);
            in_rd        = 5'($urandom_range(0, 7));
            in_reg_write = 1'($urandom);
            in_mem_read  = 1'($urandom_range(0, 2) == 0);
            exmem_reg_write = 1'($urandom);
            exmem_rd        = 5'($urandom_range(0, 7));
            exmem_result    = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_rd        = 5'($urandom_range(0, 7));
            memwb_result    = $urandom;
            ex_ready = 1'($urandom_range(0, 3) != 0);
            flush    = 1'($urandom_range(0, 9) == 0);
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
